// File: rtl/oric_sdram_bridge.sv
// oric_sdram_bridge
//   Bridges the Oric CPU RAM strobes (clk_24 side, resynchronised here) onto the
//   SDRAM port1 toggle handshake in the clk_sys (72 MHz) domain. Each new CPU
//   access becomes one request toggle. A one-deep pending slot absorbs accesses
//   that arrive while a request is in flight. A watchdog aborts a request whose
//   ack never comes back.
//
//   Optional build macro: ORIC_BRIDGE_WP_EN. It adds parameters WP_BASE/WP_TOP.
//   Writes whose address falls in [WP_BASE, WP_TOP] are dropped silently.
//
// Ports
//   clk_sys      in   system clock (same as SDRAM clock)
//   reset        in   asynchronous, active-high
//   ram_ad/ram_d in   CPU byte address / write data
//   ram_cs/oe/we in   CPU chip select, read strobe, write strobe
//   ram_q        out  read byte to the CPU; 0 while the synced chip select is low
//   busy         out  a request is outstanding or pending
//   timeout_err  out  sticky; set when an ack never arrived
//   port1_req    out  SDRAM request toggle
//   port1_ack    in   SDRAM ack toggle; the request is complete when ack == req
//   port1_a/ds/we/d   out  latched address, byte enables, write flag, {d,d}
//   port1_q      in   SDRAM read word
module oric_sdram_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
`ifdef ORIC_BRIDGE_WP_EN
    ,
    parameter logic [15:0] WP_BASE = 16'hC000,
    parameter logic [15:0] WP_TOP  = 16'hFFFF
`endif
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] ram_ad,
    input  logic [7:0]  ram_d,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    output logic [7:0]  ram_q,
    output logic        busy,
    output logic        timeout_err,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [15:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    input  logic [15:0] port1_q
);

    // Synchroniser word layout: {cs, oe, we, ad[15:0], d[7:0]}
    localparam int unsigned SW       = 27;
    localparam int unsigned TMR_W    = 8;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ---------------------------------------------------------------
    // Input synchroniser
    // ---------------------------------------------------------------
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_in;
    logic [SW-1:0] s_word;
    logic          s_cs;
    logic          s_oe;
    logic          s_we;
    logic [15:0]   s_ad;
    logic [7:0]    s_d;
    logic          cs_pre;

    assign sync_in = {ram_cs, ram_oe, ram_we, ram_ad, ram_d};
    assign s_word  = sync_q[SYNC_STAGES-1];
    assign s_cs    = s_word[26];
    assign s_oe    = s_word[25];
    assign s_we    = s_word[24];
    assign s_ad    = s_word[23:8];
    assign s_d     = s_word[7:0];

    // cs value the last sync stage will hold after the next edge; lets ram_q stay registered
    generate
        if (SYNC_STAGES > 1) begin : g_cs_pre
            assign cs_pre = sync_q[SYNC_STAGES-2][26];
        end else begin : g_cs_pre_direct
            assign cs_pre = ram_cs;
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sync_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // ---------------------------------------------------------------
    // Access detection
    // ---------------------------------------------------------------
    logic        rd_now;
    logic        wr_now;
    logic        rd_prev_q;
    logic        wr_prev_q;
    logic [15:0] ad_prev_q;
    logic        trig_raw;
    logic        wp_hit;
    logic        trig;

    assign rd_now   = s_cs & s_oe;
    assign wr_now   = s_cs & s_we;
    // A read that stays selected while the address moves is a new access
    assign trig_raw = (rd_now & ~rd_prev_q) | (wr_now & ~wr_prev_q) |
                      (rd_now & (s_ad != ad_prev_q));

`ifdef ORIC_BRIDGE_WP_EN
    assign wp_hit = wr_now & (s_ad >= WP_BASE) & (s_ad <= WP_TOP);
`else
    assign wp_hit = 1'b0;
`endif

    assign trig = trig_raw & ~wp_hit;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            ad_prev_q <= '0;
        end else begin
            rd_prev_q <= rd_now;
            wr_prev_q <= wr_now;
            ad_prev_q <= s_ad;
        end
    end

    // ---------------------------------------------------------------
    // Request FSM, pending slot and output registers
    // ---------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic             req_q,     req_d;
    logic [15:0]      a_q,       a_d;
    logic [1:0]       ds_q,      ds_d;
    logic             we_q,      we_d;
    logic [15:0]      pd_q,      pd_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic             terr_q,    terr_d;
    logic [7:0]       rdata_q,   rdata_d;
    logic [7:0]       ramq_q,    ramq_d;
    logic             busy_q,    busy_d;
    logic             pend_v_q,  pend_v_d;
    logic [15:0]      pend_ad_q, pend_ad_d;
    logic [7:0]       pend_d_q,  pend_d_d;
    logic             pend_we_q, pend_we_d;

    logic             take_pend;
    logic             take_trig;
    logic             abort;
    logic [15:0]      iss_ad;
    logic [7:0]       iss_d;
    logic             iss_we;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        a_d       = a_q;
        ds_d      = ds_q;
        we_d      = we_q;
        pd_d      = pd_q;
        timer_d   = timer_q;
        terr_d    = terr_q;
        rdata_d   = rdata_q;
        pend_v_d  = pend_v_q;
        pend_ad_d = pend_ad_q;
        pend_d_d  = pend_d_q;
        pend_we_d = pend_we_q;
        take_pend = 1'b0;
        take_trig = 1'b0;
        abort     = 1'b0;
        iss_ad    = s_ad;
        iss_d     = s_d;
        iss_we    = wr_now;

        case (state_q)
            ST_IDLE: begin
                if (pend_v_q) begin
                    take_pend = 1'b1;
                end else if (trig) begin
                    take_trig = 1'b1;
                end
            end
            ST_WAIT: begin
                if (port1_ack == req_q) begin
                    if (!we_q) begin
                        rdata_d = a_q[0] ? port1_q[15:8] : port1_q[7:0];
                    end
                    state_d = ST_DONE;
                end else if (timer_q == TMO_LAST) begin
                    // req stays toggled; the late ack realigns the handshake
                    abort   = 1'b1;
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                if (pend_v_q) begin
                    take_pend = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_pend) begin
            iss_ad   = pend_ad_q;
            iss_d    = pend_d_q;
            iss_we   = pend_we_q;
            pend_v_d = 1'b0;
        end

        // Launch: latch descriptor onto port1 and flip the request toggle
        if (take_pend || take_trig) begin
            a_d     = iss_ad;
            ds_d    = iss_we ? (iss_ad[0] ? 2'b10 : 2'b01) : 2'b11;
            we_d    = iss_we;
            pd_d    = {iss_d, iss_d};
            req_d   = ~req_q;
            timer_d = '0;
            state_d = ST_WAIT;
        end

        // Any trigger not launched directly lands in the slot (last one wins)
        if (abort) begin
            pend_v_d = 1'b0;
        end else if (trig && !take_trig) begin
            pend_v_d  = 1'b1;
            pend_ad_d = s_ad;
            pend_d_d  = s_d;
            pend_we_d = wr_now;
        end
    end

    assign busy_d = (state_d != ST_IDLE) | pend_v_d;
    assign ramq_d = cs_pre ? rdata_d : 8'h00;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            a_q       <= '0;
            ds_q      <= 2'b11;
            we_q      <= 1'b0;
            pd_q      <= '0;
            timer_q   <= '0;
            terr_q    <= 1'b0;
            rdata_q   <= '0;
            ramq_q    <= '0;
            busy_q    <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_ad_q <= '0;
            pend_d_q  <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            a_q       <= a_d;
            ds_q      <= ds_d;
            we_q      <= we_d;
            pd_q      <= pd_d;
            timer_q   <= timer_d;
            terr_q    <= terr_d;
            rdata_q   <= rdata_d;
            ramq_q    <= ramq_d;
            busy_q    <= busy_d;
            pend_v_q  <= pend_v_d;
            pend_ad_q <= pend_ad_d;
            pend_d_q  <= pend_d_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign ram_q       = ramq_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign port1_req   = req_q;
    assign port1_a     = a_q;
    assign port1_ds    = ds_q;
    assign port1_we    = we_q;
    assign port1_d     = pd_q;

endmodule

// File: tb/tb_oric_sdram_bridge.sv
// Testbench for oric_sdram_bridge: fixed vectors, a held-read pending case,
// randomized accesses against a byte-memory model, watchdog abort, and async reset.
module tb_oric_sdram_bridge;

    logic        clk_sys;
    logic        reset;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic        ram_cs;
    logic        ram_oe;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic        busy;
    logic        timeout_err;
    logic        port1_req;
    logic        port1_ack;
    logic [15:0] port1_a;
    logic [1:0]  port1_ds;
    logic        port1_we;
    logic [15:0] port1_d;
    logic [15:0] port1_q;

    oric_sdram_bridge #(.SYNC_STAGES(2), .TIMEOUT(255)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ram_ad(ram_ad), .ram_d(ram_d), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_q(ram_q), .busy(busy), .timeout_err(timeout_err),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_we(port1_we), .port1_d(port1_d), .port1_q(port1_q)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passes = 0;
    int toggles = 0;

    // Every change of the request line, including the reset-forced one
    always @(port1_req) toggles++;

    logic [7:0] mem [0:65535];

    typedef struct {
        bit          we;
        logic [15:0] ad;
        logic [7:0]  d;
        logic [15:0] q;
        logic [1:0]  ds;
        logic [7:0]  rq;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic wait_toggles(input int target);
        int n = 0;
        while (toggles < target && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (busy && n < 40);
    endtask

    task automatic ack_now(input logic [15:0] word);
        @(posedge clk_sys);
        #1;
        port1_q   = word;
        port1_ack = port1_req;
    endtask

    task automatic release_strobes();
        @(posedge clk_sys);
        #1;
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        ram_we = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic start_access(input bit we, input logic [15:0] ad, input logic [7:0] d);
        @(posedge clk_sys);
        #1;
        ram_ad = ad;
        ram_d  = d;
        ram_cs = 1'b1;
        ram_oe = !we;
        ram_we = we;
    endtask

    // One complete CPU access with the bench acting as SDRAM
    task automatic do_access(input string tag, input bit we, input logic [15:0] ad,
                             input logic [7:0] d, input logic [15:0] qword, input int dly,
                             input logic [1:0] exp_ds, input logic [7:0] exp_q);
        int t0;
        int n;
        t0 = toggles;
        start_access(we, ad, d);
        wait_toggles(t0 + 1);
        chk({tag, " req_toggle"}, 32'(toggles - t0), 32'd1);
        chk({tag, " port1_a"},  {16'h0, port1_a}, {16'h0, ad});
        chk({tag, " port1_ds"}, {30'h0, port1_ds}, {30'h0, exp_ds});
        chk({tag, " port1_we"}, {31'h0, port1_we}, {31'h0, we});
        chk({tag, " port1_d"},  {16'h0, port1_d}, {16'h0, d, d});
        chk({tag, " busy_hi"},  {31'h0, busy}, 32'd1);
        repeat (dly) @(posedge clk_sys);
        ack_now(qword);
        wait_idle(n);
        chk({tag, " busy_drop_cycles"}, 32'(n), 32'd3);
        if (!we) chk({tag, " ram_q"}, {24'h0, ram_q}, {24'h0, exp_q});
        chk({tag, " single_toggle"}, 32'(toggles - t0), 32'd1);
        release_strobes();
        chk({tag, " ram_q_cs_low"}, {24'h0, ram_q}, 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int k;
        vecs[0] = '{we: 1'b0, ad: 16'h1235, d: 8'h00, q: 16'hAB12, ds: 2'b11, rq: 8'hAB};
        vecs[1] = '{we: 1'b1, ad: 16'h0400, d: 8'h5A, q: 16'h0000, ds: 2'b01, rq: 8'h00};
        vecs[2] = '{we: 1'b0, ad: 16'h2000, d: 8'h11, q: 16'h34CD, ds: 2'b11, rq: 8'hCD};
        vecs[3] = '{we: 1'b1, ad: 16'h0401, d: 8'hA5, q: 16'h0000, ds: 2'b10, rq: 8'h00};
        vecs[4] = '{we: 1'b0, ad: 16'hFFFF, d: 8'h00, q: 16'h7E81, ds: 2'b11, rq: 8'h7E};
        vecs[5] = '{we: 1'b0, ad: 16'h0000, d: 8'h3C, q: 16'h55AA, ds: 2'b11, rq: 8'hAA};
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);

        reset = 1'b1; ram_ad = '0; ram_d = '0; ram_cs = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
        port1_ack = 1'b0; port1_q = '0;
        repeat (3) @(negedge clk_sys);
        chk("rst ram_q", {24'h0, ram_q}, 32'd0);
        chk("rst busy", {31'h0, busy}, 32'd0);
        chk("rst timeout_err", {31'h0, timeout_err}, 32'd0);
        chk("rst req", {31'h0, port1_req}, 32'd0);
        chk("rst port1_ds", {30'h0, port1_ds}, 32'd3);
        chk("rst port1_a", {16'h0, port1_a}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Fixed vectors
        for (int i = 0; i < 6; i++)
            do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].ad, vecs[i].d,
                      vecs[i].q, i % 3, vecs[i].ds, vecs[i].rq);

        // Held read, address steps while the first request is outstanding
        t0 = toggles;
        start_access(1'b0, 16'h0010, 8'h00);
        wait_toggles(t0 + 1);
        chk("pend first_a", {16'h0, port1_a}, 32'h0010);
        @(posedge clk_sys);
        #1 ram_ad = 16'h0011;
        repeat (6) @(negedge clk_sys);
        chk("pend no_early_issue", 32'(toggles - t0), 32'd1);
        chk("pend busy", {31'h0, busy}, 32'd1);
        ack_now(16'h1111);
        wait_toggles(t0 + 2);
        chk("pend second_toggle", 32'(toggles - t0), 32'd2);
        chk("pend second_a", {16'h0, port1_a}, 32'h0011);
        chk("pend second_ds", {30'h0, port1_ds}, 32'd3);
        ack_now(16'hC3D4);
        wait_idle(n);
        chk("pend ram_q", {24'h0, ram_q}, 32'h00C3);
        chk("pend total_toggles", 32'(toggles - t0), 32'd2);
        release_strobes();

        // Randomized accesses against the byte-memory model
        for (int i = 0; i < 30; i++) begin
            bit          we;
            logic [15:0] ad;
            logic [7:0]  d;
            logic [15:0] word;
            logic [1:0]  eds;
            we   = 1'($urandom_range(0, 1));
            ad   = 16'h2000 + 16'($urandom_range(0, 15));
            d    = 8'($urandom);
            // SDRAM returns the aligned word holding this byte
            word = {mem[{ad[15:1], 1'b1}], mem[{ad[15:1], 1'b0}]};
            if (we) eds = (ad % 2 == 1) ? 2'b10 : 2'b01;
            else    eds = 2'b11;
            do_access($sformatf("rnd%0d", i), we, ad, d, word, int'($urandom_range(0, 4)),
                      eds, mem[ad]);
            if (we) mem[ad] = d;
        end

        // Ack never arrives: watchdog aborts after TIMEOUT cycles
        t0 = toggles;
        start_access(1'b0, 16'h3000, 8'h00);
        wait_toggles(t0 + 1);
        k = 0;
        while (!timeout_err && k < 400) begin
            @(negedge clk_sys);
            k++;
        end
        chk("tmo cycles", 32'(k), 32'd255);
        chk("tmo err", {31'h0, timeout_err}, 32'd1);
        chk("tmo busy", {31'h0, busy}, 32'd0);
        chk("tmo toggles", 32'(toggles - t0), 32'd1);
        release_strobes();
        @(posedge clk_sys);
        #1 port1_ack = port1_req;
        do_access("post_tmo", 1'b0, 16'h3002, 8'h00, 16'h9F42, 1, 2'b11, 8'h42);
        chk("tmo sticky", {31'h0, timeout_err}, 32'd1);

        // Reset in the middle of a request
        t0 = toggles;
        start_access(1'b1, 16'h0500, 8'h77);
        wait_toggles(t0 + 1);
        chk("rstw launched", {31'h0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstw busy", {31'h0, busy}, 32'd0);
        chk("rstw req", {31'h0, port1_req}, 32'd0);
        chk("rstw timeout_err", {31'h0, timeout_err}, 32'd0);
        chk("rstw port1_ds", {30'h0, port1_ds}, 32'd3);
        chk("rstw port1_we", {31'h0, port1_we}, 32'd0);
        chk("rstw port1_d", {16'h0, port1_d}, 32'd0);
        chk("rstw port1_a", {16'h0, port1_a}, 32'd0);
        ram_cs = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
        port1_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        t0 = toggles;
        repeat (10) @(negedge clk_sys);
        chk("rstw no_toggle", 32'(toggles - t0), 32'd0);
        chk("rstw idle", {31'h0, busy}, 32'd0);
        do_access("post_rst", 1'b0, 16'h1235, 8'h00, 16'hAB12, 0, 2'b11, 8'hAB);

`ifdef ORIC_BRIDGE_WP_EN
        t0 = toggles;
        start_access(1'b1, 16'hC000, 8'h99);
        repeat (10) @(negedge clk_sys);
        chk("wp swallowed", 32'(toggles - t0), 32'd0);
        chk("wp busy", {31'h0, busy}, 32'd0);
        release_strobes();
        do_access("wp below", 1'b1, 16'hBFFF, 8'h66, 16'h0000, 0, 2'b10, 8'h00);
        do_access("wp read", 1'b0, 16'hC000, 8'h00, 16'h1234, 0, 2'b11, 8'h34);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
